// File: rtl/jump_issue_ctrl.sv
// jump_issue_ctrl: in-order issue queue and resolve logic for e_jump.
// Buffers branch uops, wakes operands from writeback, issues the head,
// checks the prediction and reports to the ROB / front end.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush_i             backend flush, empties queue
//   in_*                dispatch bundle (valid/ready handshake)
//   wb_valid/tag/data   writeback wakeup ports
//   ju_*_o              head operands to e_jump (combinational)
//   ju_res_i/ju_jump_i  e_jump target and taken result
//   res_*_o             registered resolve report to ROB
//   redirect*_o         registered mispredict redirect
//   count_o             occupied entries
module jump_issue_ctrl #(
  parameter int DEPTH    = 4,
  parameter int PREG_W   = 6,
  parameter int ROB_W    = 6,
  parameter int WB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [5:0]                 in_op_i,
  input  logic [31:0]                in_pc_i,
  input  logic [31:0]                in_imm_i,
  input  logic [PREG_W-1:0]          in_r0_tag_i,
  input  logic                       in_r0_rdy_i,
  input  logic [31:0]                in_r0_val_i,
  input  logic [PREG_W-1:0]          in_r1_tag_i,
  input  logic                       in_r1_rdy_i,
  input  logic [31:0]                in_r1_val_i,
  input  logic                       in_pred_taken_i,
  input  logic [31:0]                in_pred_tgt_i,
  input  logic [ROB_W-1:0]           in_rob_id_i,
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [WB_PORTS*PREG_W-1:0] wb_tag_i,
  input  logic [WB_PORTS*32-1:0]     wb_data_i,
  output logic [31:0]                ju_r0_o,
  output logic [31:0]                ju_r1_o,
  output logic [31:0]                ju_pc_o,
  output logic [31:0]                ju_imm_o,
  output logic [5:0]                 ju_op_o,
  input  logic [31:0]                ju_res_i,
  input  logic                       ju_jump_i,
  output logic                       res_valid_o,
  output logic [ROB_W-1:0]           res_rob_id_o,
  output logic                       res_taken_o,
  output logic [31:0]                res_target_o,
  output logic                       redirect_o,
  output logic [31:0]                redirect_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              v;
    logic [5:0]        op;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [PREG_W-1:0] t0;
    logic              rdy0;
    logic [31:0]       d0;
    logic [PREG_W-1:0] t1;
    logic              rdy1;
    logic [31:0]       d1;
    logic              pt;
    logic [31:0]       ptgt;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t              r_q [DEPTH];
  ent_t              w_q_nxt [DEPTH];
  ent_t              w_in;
  ent_t              w_head;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_res_valid;
  logic [ROB_W-1:0]  r_res_rob;
  logic              r_res_taken;
  logic [31:0]       r_res_tgt;
  logic              r_redirect;

  logic              w_issue;
  logic              w_fire;
  logic              w_mis;
  logic              w_kill;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_tgt;

  // Any valid port with a matching tag.
  function automatic logic wb_hit(input logic [PREG_W-1:0] tag);
    logic h;
    h = 1'b0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid_i[p] && wb_tag_i[p*PREG_W +: PREG_W] == tag)
        h = 1'b1;
    return h;
  endfunction

  // Walk ports high to low so the lowest matching index wins.
  function automatic logic [31:0] wb_data(input logic [PREG_W-1:0] tag);
    logic [31:0] d;
    d = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--)
      if (wb_valid_i[p] && wb_tag_i[p*PREG_W +: PREG_W] == tag)
        d = wb_data_i[p*32 +: 32];
    return d;
  endfunction

  assign w_head  = r_q[r_head];
  assign w_issue = w_head.v & w_head.rdy0 & w_head.rdy1;
  assign w_fire  = w_issue & ~flush_i;
  assign w_tgt   = ju_jump_i ? ju_res_i : w_head.pc + 32'd4;
  assign w_mis   = (ju_jump_i != w_head.pt)
                 | (ju_jump_i & (ju_res_i != w_head.ptgt));
  // A mispredict kills younger entries exactly like a flush.
  assign w_kill  = flush_i | (w_fire & w_mis);
  assign w_pop   = w_fire;
  assign w_push  = in_valid_i & in_ready_o & ~w_kill;

  assign in_ready_o = (r_count != CW'(DEPTH));
  assign count_o    = r_count;

  assign ju_r0_o  = w_head.d0;
  assign ju_r1_o  = w_head.d1;
  assign ju_pc_o  = w_head.pc;
  assign ju_imm_o = w_head.imm;
  assign ju_op_o  = w_head.op;

  assign res_valid_o   = r_res_valid;
  assign res_rob_id_o  = r_res_rob;
  assign res_taken_o   = r_res_taken;
  assign res_target_o  = r_res_tgt;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_res_tgt;

  // Incoming uop, with same-cycle wakeup of its operands.
  always_comb begin
    w_in      = '0;
    w_in.v    = 1'b1;
    w_in.op   = in_op_i;
    w_in.pc   = in_pc_i;
    w_in.imm  = in_imm_i;
    w_in.t0   = in_r0_tag_i;
    w_in.t1   = in_r1_tag_i;
    w_in.pt   = in_pred_taken_i;
    w_in.ptgt = in_pred_tgt_i;
    w_in.rob  = in_rob_id_i;
    w_in.rdy0 = in_r0_rdy_i;
    w_in.d0   = in_r0_val_i;
    w_in.rdy1 = in_r1_rdy_i;
    w_in.d1   = in_r1_val_i;
    if (!in_r0_rdy_i && wb_hit(in_r0_tag_i)) begin
      w_in.rdy0 = 1'b1;
      w_in.d0   = wb_data(in_r0_tag_i);
    end
    if (!in_r1_rdy_i && wb_hit(in_r1_tag_i)) begin
      w_in.rdy1 = 1'b1;
      w_in.d1   = wb_data(in_r1_tag_i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_q_nxt[i] = r_q[i];
      if (r_q[i].v && !r_q[i].rdy0 && wb_hit(r_q[i].t0)) begin
        w_q_nxt[i].rdy0 = 1'b1;
        w_q_nxt[i].d0   = wb_data(r_q[i].t0);
      end
      if (r_q[i].v && !r_q[i].rdy1 && wb_hit(r_q[i].t1)) begin
        w_q_nxt[i].rdy1 = 1'b1;
        w_q_nxt[i].d1   = wb_data(r_q[i].t1);
      end
    end
    if (w_pop)
      w_q_nxt[r_head].v = 1'b0;
    if (w_push)
      w_q_nxt[r_tail] = w_in;
    if (w_kill)
      for (int i = 0; i < DEPTH; i++)
        w_q_nxt[i].v = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= w_q_nxt[i];
    end
  end

  // Pointers; a kill collapses the queue onto the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_kill) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_rob   <= '0;
      r_res_taken <= 1'b0;
      r_res_tgt   <= '0;
      r_redirect  <= 1'b0;
    end else begin
      r_res_valid <= w_fire;
      r_redirect  <= w_fire & w_mis;
      if (w_fire) begin
        r_res_rob   <= w_head.rob;
        r_res_taken <= ju_jump_i;
        r_res_tgt   <= w_tgt;
      end
    end
  end

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// tb_jump_issue_ctrl: directed scenarios for jump_issue_ctrl.
// Each task drives one scenario and checks hand-computed values.
module tb_jump_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int PREG_W = 6;
  localparam int ROB_W = 6;
  localparam int WB_PORTS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [5:0] in_op_i = '0;
  logic [31:0] in_pc_i = '0;
  logic [31:0] in_imm_i = '0;
  logic [PREG_W-1:0] in_r0_tag_i = '0;
  logic in_r0_rdy_i = 1'b0;
  logic [31:0] in_r0_val_i = '0;
  logic [PREG_W-1:0] in_r1_tag_i = '0;
  logic in_r1_rdy_i = 1'b0;
  logic [31:0] in_r1_val_i = '0;
  logic in_pred_taken_i = 1'b0;
  logic [31:0] in_pred_tgt_i = '0;
  logic [ROB_W-1:0] in_rob_id_i = '0;
  logic [WB_PORTS-1:0] wb_valid_i = '0;
  logic [WB_PORTS*PREG_W-1:0] wb_tag_i = '0;
  logic [WB_PORTS*32-1:0] wb_data_i = '0;
  logic [31:0] ju_r0_o, ju_r1_o, ju_pc_o, ju_imm_o;
  logic [5:0] ju_op_o;
  logic [31:0] ju_res_i = '0;
  logic ju_jump_i = 1'b0;
  logic res_valid_o;
  logic [ROB_W-1:0] res_rob_id_o;
  logic res_taken_o;
  logic [31:0] res_target_o;
  logic redirect_o;
  logic [31:0] redirect_pc_o;
  logic [2:0] count_o;

  int vectors = 0;
  int miscompares = 0;

  jump_issue_ctrl #(
    .DEPTH(DEPTH), .PREG_W(PREG_W),
    .ROB_W(ROB_W), .WB_PORTS(WB_PORTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_op_i(in_op_i), .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
    .in_r0_tag_i(in_r0_tag_i), .in_r0_rdy_i(in_r0_rdy_i),
    .in_r0_val_i(in_r0_val_i),
    .in_r1_tag_i(in_r1_tag_i), .in_r1_rdy_i(in_r1_rdy_i),
    .in_r1_val_i(in_r1_val_i),
    .in_pred_taken_i(in_pred_taken_i), .in_pred_tgt_i(in_pred_tgt_i),
    .in_rob_id_i(in_rob_id_i),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
    .ju_r0_o(ju_r0_o), .ju_r1_o(ju_r1_o), .ju_pc_o(ju_pc_o),
    .ju_imm_o(ju_imm_o), .ju_op_o(ju_op_o),
    .ju_res_i(ju_res_i), .ju_jump_i(ju_jump_i),
    .res_valid_o(res_valid_o), .res_rob_id_o(res_rob_id_o),
    .res_taken_o(res_taken_o), .res_target_o(res_target_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid_i = 1'b0;
    wb_valid_i = '0;
    flush_i = 1'b0;
    ju_jump_i = 1'b0;
    ju_res_i = '0;
  endtask

  // Drive one dispatch; operand values are 5 when ready.
  task automatic disp(
    input logic [31:0] pc,
    input logic [PREG_W-1:0] t0, input logic rdy0,
    input logic [PREG_W-1:0] t1, input logic rdy1,
    input logic pt, input logic [31:0] ptgt,
    input logic [ROB_W-1:0] rob
  );
    in_valid_i = 1'b1;
    in_op_i = 6'h11;
    in_pc_i = pc;
    in_imm_i = 32'h20;
    in_r0_tag_i = t0;
    in_r0_rdy_i = rdy0;
    in_r0_val_i = 32'h5;
    in_r1_tag_i = t1;
    in_r1_rdy_i = rdy1;
    in_r1_val_i = 32'h5;
    in_pred_taken_i = pt;
    in_pred_tgt_i = ptgt;
    in_rob_id_i = rob;
  endtask

  task automatic wb(
    input logic v0, input logic [PREG_W-1:0] t0, input logic [31:0] d0,
    input logic v1, input logic [PREG_W-1:0] t1, input logic [31:0] d1
  );
    wb_valid_i = {v1, v0};
    wb_tag_i = {t1, t0};
    wb_data_i = {d1, d0};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vectors++; if (count_o !== 3'd0) begin miscompares++;
      $display("FAIL por_count got %0d exp 0", count_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL por_ready got %b exp 1", in_ready_o); end
    vectors++; if (res_valid_o !== 1'b0 || redirect_o !== 1'b0) begin
      miscompares++;
      $display("FAIL por_pulses got %b%b exp 00", res_valid_o, redirect_o); end
    vectors++; if (ju_pc_o !== 32'h0 || res_target_o !== 32'h0) begin
      miscompares++;
      $display("FAIL por_data got %h %h exp 0 0", ju_pc_o, res_target_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      disp(32'h100 + 32'(i * 4), 6'd40, 1'b0, 6'd0, 1'b1,
           1'b0, 32'h0, ROB_W'(i));
      tick();
    end
    idle();
    vectors++; if (count_o !== 3'd3) begin miscompares++;
      $display("FAIL pre_rst_count got %0d exp 3", count_o); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (count_o !== 3'd0) begin miscompares++;
      $display("FAIL rst_count got %0d exp 0", count_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++;
      $display("FAIL rst_ready got %b exp 1", in_ready_o); end
    vectors++; if (res_valid_o !== 1'b0 || redirect_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pulses got %b%b exp 00", res_valid_o, redirect_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue;
    disp(32'h1C000000, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 32'h1C000020, 6'd1);
    tick();
    idle();
    vectors++; if (count_o !== 3'd1) begin miscompares++;
      $display("FAIL beq_count got %0d exp 1", count_o); end
    vectors++; if (ju_r0_o !== 32'h5 || ju_r1_o !== 32'h5) begin
      miscompares++;
      $display("FAIL beq_ops got %h %h exp 5 5", ju_r0_o, ju_r1_o); end
    vectors++;
    if (ju_pc_o !== 32'h1C000000 || ju_imm_o !== 32'h20 || ju_op_o !== 6'h11)
    begin miscompares++;
      $display("FAIL beq_head got %h %h %h exp 1c000000 20 11",
               ju_pc_o, ju_imm_o, ju_op_o); end
    vectors++; if (res_valid_o !== 1'b0) begin miscompares++;
      $display("FAIL beq_early got %b exp 0", res_valid_o); end
    ju_jump_i = 1'b1;
    ju_res_i = 32'h1C000020;
    tick();
    idle();
    vectors++; if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'd1) begin
      miscompares++;
      $display("FAIL beq_res got %b rob %0d exp 1 rob 1",
               res_valid_o, res_rob_id_o); end
    vectors++;
    if (res_taken_o !== 1'b1 || res_target_o !== 32'h1C000020) begin
      miscompares++;
      $display("FAIL beq_tgt got %b %h exp 1 1c000020",
               res_taken_o, res_target_o); end
    vectors++; if (redirect_o !== 1'b0 || count_o !== 3'd0) begin
      miscompares++;
      $display("FAIL beq_redir got %b cnt %0d exp 0 0", redirect_o, count_o);
    end
    tick();
    vectors++; if (res_valid_o !== 1'b0) begin miscompares++;
      $display("FAIL beq_pulse got %b exp 0", res_valid_o); end
  endtask

  task automatic test_wakeup;
    disp(32'h1C000100, 6'd3, 1'b1, 6'd7, 1'b0, 1'b0, 32'h0, 6'd2);
    tick();
    idle();
    tick();
    tick();
    wb(1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'h9);
    vectors++; if (res_valid_o !== 1'b0 || count_o !== 3'd1) begin
      miscompares++;
      $display("FAIL wk_wait got %b cnt %0d exp 0 1", res_valid_o, count_o);
    end
    tick();
    idle();
    vectors++; if (ju_r1_o !== 32'h9) begin miscompares++;
      $display("FAIL wk_r1 got %h exp 9", ju_r1_o); end
    vectors++; if (res_valid_o !== 1'b0) begin miscompares++;
      $display("FAIL wk_nobypass got %b exp 0", res_valid_o); end
    tick();
    vectors++;
    if (res_valid_o !== 1'b1 || res_target_o !== 32'h1C000104 ||
        res_taken_o !== 1'b0) begin miscompares++;
      $display("FAIL wk_res got %b %h %b exp 1 1c000104 0",
               res_valid_o, res_target_o, res_taken_o); end
    tick();
  endtask

  task automatic test_wake_prio;
    disp(32'h100, 6'd12, 1'b0, 6'd13, 1'b0, 1'b0, 32'h0, 6'd3);
    wb(1'b1, 6'd13, 32'h55, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    wb(1'b1, 6'd12, 32'hAA, 1'b1, 6'd12, 32'hBB);
    tick();
    idle();
    vectors++; if (ju_r0_o !== 32'hAA) begin miscompares++;
      $display("FAIL prio_r0 got %h exp aa", ju_r0_o); end
    vectors++; if (ju_r1_o !== 32'h55) begin miscompares++;
      $display("FAIL prio_inwake got %h exp 55", ju_r1_o); end
    tick();
    vectors++; if (res_valid_o !== 1'b1 || res_target_o !== 32'h104) begin
      miscompares++;
      $display("FAIL prio_res got %b %h exp 1 104", res_valid_o, res_target_o);
    end
    tick();
  endtask

  task automatic test_mispredict;
    disp(32'h1C000030, 6'd20, 1'b0, 6'd0, 1'b1, 1'b0, 32'h1C000034, 6'd10);
    tick();
    disp(32'h1C000034, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd11);
    tick();
    disp(32'h1C000038, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd12);
    tick();
    idle();
    wb(1'b1, 6'd20, 32'h1, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    vectors++; if (count_o !== 3'd3 || ju_pc_o !== 32'h1C000030) begin
      miscompares++;
      $display("FAIL mp_pre got %0d %h exp 3 1c000030", count_o, ju_pc_o); end
    ju_jump_i = 1'b1;
    ju_res_i = 32'h1C000040;
    disp(32'h1C00003C, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd13);
    tick();
    idle();
    vectors++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1C000040)
    begin miscompares++;
      $display("FAIL mp_redir got %b %h exp 1 1c000040",
               redirect_o, redirect_pc_o); end
    vectors++; if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'd10) begin
      miscompares++;
      $display("FAIL mp_res got %b rob %0d exp 1 rob 10",
               res_valid_o, res_rob_id_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++;
      $display("FAIL mp_count got %0d exp 0", count_o); end
    tick();
    vectors++; if (redirect_o !== 1'b0 || res_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mp_after got %b%b exp 00", redirect_o, res_valid_o); end
    tick();
    vectors++; if (res_valid_o !== 1'b0 || count_o !== 3'd0) begin
      miscompares++;
      $display("FAIL mp_quiet got %b cnt %0d exp 0 0", res_valid_o, count_o);
    end
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (in_ready_o !== 1'b1) begin miscompares++;
        $display("FAIL fill_ready%0d got %b exp 1", i, in_ready_o); end
      disp(32'h2000 + 32'(i * 16), 6'(30 + i), 1'b0, 6'd0, 1'b1,
           1'b0, 32'h0, 6'(20 + i));
      tick();
    end
    vectors++; if (in_ready_o !== 1'b0 || count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL full got %b cnt %0d exp 0 4", in_ready_o, count_o); end
    disp(32'h2040, 6'd34, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 6'd24);
    tick();
    idle();
    vectors++; if (count_o !== 3'd4) begin miscompares++;
      $display("FAIL full_push got %0d exp 4", count_o); end
    wb(1'b1, 6'd33, 32'h0, 1'b1, 6'd32, 32'h0);
    tick();
    idle();
    vectors++; if (count_o !== 3'd4 || res_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL inorder_hold got %0d %b exp 4 0", count_o, res_valid_o);
    end
    wb(1'b1, 6'd31, 32'h0, 1'b1, 6'd30, 32'h0);
    tick();
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      vectors++; if (ju_pc_o !== 32'h2000 + 32'(k * 16)) begin miscompares++;
        $display("FAIL drain_pc%0d got %h exp %h", k, ju_pc_o,
                 32'h2000 + 32'(k * 16)); end
      tick();
      vectors++;
      if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'(20 + k) ||
          res_target_o !== 32'h2004 + 32'(k * 16)) begin miscompares++;
        $display("FAIL drain_res%0d got %b %0d %h exp 1 %0d %h", k,
                 res_valid_o, res_rob_id_o, res_target_o, 20 + k,
                 32'h2004 + 32'(k * 16)); end
    end
    vectors++; if (count_o !== 3'd0) begin miscompares++;
      $display("FAIL drain_count got %0d exp 0", count_o); end
    tick();
    vectors++; if (res_valid_o !== 1'b0) begin miscompares++;
      $display("FAIL drain_end got %b exp 0", res_valid_o); end
    for (int k = 0; k < DEPTH; k++) begin
      disp((k == DEPTH - 1) ? 32'hFFFFFFFC : 32'h3000 + 32'(k * 16),
           6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'(30 + k));
      tick();
      vectors++; if (count_o !== 3'd1) begin miscompares++;
        $display("FAIL b2b_count%0d got %0d exp 1", k, count_o); end
      if (k > 0) begin
        vectors++;
        if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'(29 + k)) begin
          miscompares++;
          $display("FAIL b2b_res%0d got %b %0d exp 1 %0d", k,
                   res_valid_o, res_rob_id_o, 29 + k); end
      end
    end
    idle();
    tick();
    vectors++;
    if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'd33 ||
        res_target_o !== 32'h0) begin miscompares++;
      $display("FAIL pc_wrap got %b %0d %h exp 1 33 0",
               res_valid_o, res_rob_id_o, res_target_o); end
    tick();
  endtask

  task automatic test_flush;
    disp(32'h4000, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd40);
    tick();
    vectors++; if (count_o !== 3'd1) begin miscompares++;
      $display("FAIL fl_pre got %0d exp 1", count_o); end
    flush_i = 1'b1;
    ju_jump_i = 1'b1;
    ju_res_i = 32'h5000;
    disp(32'h4004, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd41);
    tick();
    idle();
    vectors++; if (res_valid_o !== 1'b0 || redirect_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fl_pulse got %b%b exp 00", res_valid_o, redirect_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++;
      $display("FAIL fl_count got %0d exp 0", count_o); end
    disp(32'h6000, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 6'd42);
    tick();
    idle();
    vectors++; if (count_o !== 3'd1 || ju_pc_o !== 32'h6000) begin
      miscompares++;
      $display("FAIL fl_accept got %0d %h exp 1 6000", count_o, ju_pc_o); end
    tick();
    vectors++;
    if (res_valid_o !== 1'b1 || res_rob_id_o !== 6'd42 ||
        res_target_o !== 32'h6004) begin miscompares++;
      $display("FAIL fl_res got %b %0d %h exp 1 42 6004",
               res_valid_o, res_rob_id_o, res_target_o); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_wake_prio();
    test_mispredict();
    test_full_wrap();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
